// File: rtl/mean_operand_accumulator_if.sv
// Bus bundle between the frame-mean accumulator and its environment.
//   slave  : the accumulator itself (consumes samples and divider results,
//            drives the divider operands and the mean result).
//   master : the environment (sample source, divider, result sink).
// Signals:
//   sample_valid/sample_data/frame_end   sample stream into the accumulator
//   sample_ready                         accumulator can take samples
//   div_en/g_dividend_Q/g_divider_Q      divide request and operands
//   quotient/done                        divider result
//   mean_valid/mean_out/zero_frame       frame mean result
//   overrun/timeout_err                  sticky error flags
interface mean_operand_accumulator_if;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        frame_end;
  logic        sample_ready;
  logic        div_en;
  logic [63:0] g_dividend_Q;
  logic [63:0] g_divider_Q;
  logic [31:0] quotient;
  logic        done;
  logic        mean_valid;
  logic [31:0] mean_out;
  logic        zero_frame;
  logic        overrun;
  logic        timeout_err;

  modport slave (
    input  sample_valid, sample_data, frame_end, quotient, done,
    output sample_ready, div_en, g_dividend_Q, g_divider_Q,
           mean_valid, mean_out, zero_frame, overrun, timeout_err
  );

  modport master (
    output sample_valid, sample_data, frame_end, quotient, done,
    input  sample_ready, div_en, g_dividend_Q, g_divider_Q,
           mean_valid, mean_out, zero_frame, overrun, timeout_err
  );
endinterface

// File: rtl/mean_operand_accumulator.sv
// Frame-mean accumulator feeding a binary divider.
// Sums a frame of unsigned 32-bit samples into a 64-bit dividend and counts
// them into the divisor, fires a one-cycle div_en, waits (bounded) for the
// divider's done and republishes the quotient as the frame mean.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    mean_operand_accumulator_if.slave (sample stream, divider
//          request/response, mean result, sticky error flags)
// Parameters:
//   MAX_COUNT  samples after which a frame is force-closed
//   TIMEOUT    WAIT cycles allowed before a division is abandoned
module mean_operand_accumulator #(
  parameter int unsigned MAX_COUNT = 65535,
  parameter int unsigned TIMEOUT   = 8192
) (
  input  logic                          clk,
  input  logic                          reset,
  mean_operand_accumulator_if.slave     bus
);

  typedef enum logic [1:0] {ACCUM, ISSUE, WAIT, OUTPUT} state_t;

  state_t      state_q;
  logic [63:0] sum_q, sum_d;
  logic [31:0] count_q, count_d;
  logic [31:0] tmo_q;
  logic        close;
  logic        sample_ready_q;
  logic        div_en_q;
  logic [63:0] dividend_q;
  logic [63:0] divider_q;
  logic        mean_valid_q;
  logic [31:0] mean_out_q;
  logic        zero_frame_q;
  logic        overrun_q;
  logic        timeout_err_q;

  // Sum/count as they would be with this cycle's sample folded in, so a
  // sample arriving together with frame_end is part of the closing frame.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sum_d   = sum_q;
    count_d = count_q;
    if (bus.sample_valid) begin
      sum_d   = sum_q + {32'b0, bus.sample_data};
      count_d = count_q + 32'd1;
    end
    close = bus.frame_end || (bus.sample_valid && (count_d == MAX_COUNT));
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACCUM;
      sum_q          <= '0;
      count_q        <= '0;
      tmo_q          <= '0;
      sample_ready_q <= 1'b1;
      div_en_q       <= 1'b0;
      dividend_q     <= '0;
      divider_q      <= '0;
      mean_valid_q   <= 1'b0;
      mean_out_q     <= '0;
      zero_frame_q   <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      div_en_q     <= 1'b0;
      mean_valid_q <= 1'b0;
      zero_frame_q <= 1'b0;

      // sample_ready_q is high exactly in ACCUM, so it doubles as "busy".
      if (bus.sample_valid && !sample_ready_q) overrun_q <= 1'b1;

      case (state_q)
        ACCUM: begin
          sum_q   <= sum_d;
          count_q <= count_d;
          if (close) begin
            sample_ready_q <= 1'b0;
            if (count_d == 32'd0) begin
              // Empty frame: report a zero mean without touching the divider.
              state_q      <= OUTPUT;
              mean_out_q   <= '0;
              mean_valid_q <= 1'b1;
              zero_frame_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              div_en_q   <= 1'b1;
              dividend_q <= sum_d;
              divider_q  <= {32'b0, count_d};
            end
          end
        end

        ISSUE: begin
          state_q <= WAIT;
          tmo_q   <= '0;
        end

        WAIT: begin
          if (bus.done) begin
            state_q      <= OUTPUT;
            mean_out_q   <= bus.quotient;
            mean_valid_q <= 1'b1;
            sum_q        <= '0;
            count_q      <= '0;
            dividend_q   <= '0;
            divider_q    <= '0;
          end else if (tmo_q == TIMEOUT - 1) begin
            // Divider is presumed lost: drop the frame, keep the old mean.
            state_q        <= ACCUM;
            sample_ready_q <= 1'b1;
            timeout_err_q  <= 1'b1;
            sum_q          <= '0;
            count_q        <= '0;
            dividend_q     <= '0;
            divider_q      <= '0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end

        OUTPUT: begin
          state_q        <= ACCUM;
          sample_ready_q <= 1'b1;
          sum_q          <= '0;
          count_q        <= '0;
          dividend_q     <= '0;
          divider_q      <= '0;
        end

        default: begin
          state_q        <= ACCUM;
          sample_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.div_en       = div_en_q;
  assign bus.g_dividend_Q = dividend_q;
  assign bus.g_divider_Q  = divider_q;
  assign bus.mean_valid   = mean_valid_q;
  assign bus.mean_out     = mean_out_q;
  assign bus.zero_frame   = zero_frame_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: doc/mean_operand_accumulator.md
Name: mean_operand_accumulator

Overview:
- Upstream feeder for the binary divider: accumulates a frame of unsigned 32-bit samples into a 64-bit sum (dividend) and a sample count (divisor).
- Issues a one-cycle divide request and waits for the divider's done.
- Captures the 32-bit quotient and presents it downstream as the frame mean.
- Drives the divider's div_en, g_dividend_Q and g_divider_Q inputs directly; consumes its quotient and done outputs.

Parameters:
MAX_COUNT, 65535, samples per frame before the frame is force-closed (1..2^32-1)
TIMEOUT, 8192, cycles allowed in WAIT for done before the division is aborted

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_valid  input  1  sample_data valid this cycle
sample_data  input  32  unsigned sample
frame_end  input  1  close current frame (may coincide with sample_valid or occur alone)
sample_ready  output  1  high only in ACCUM; samples offered while low are dropped
div_en  output  1  one-cycle divide start pulse to divider
g_dividend_Q  output  64  accumulated sum, stable from ISSUE through WAIT
g_divider_Q  output  64  {32'b0, count}, stable from ISSUE through WAIT
quotient  input  32  divider result, sampled on done
done  input  1  divider completion
mean_valid  output  1  one-cycle pulse, mean_out updated
mean_out  output  32  last frame mean, held until next result
zero_frame  output  1  with mean_valid: frame had zero samples
overrun  output  1  sticky: a sample was dropped (sample_valid while sample_ready=0)
timeout_err  output  1  sticky: done not seen within TIMEOUT cycles

Behaviour:
- Reset (synchronous, active-high) takes effect at the next edge and works in any state, including mid-division. It sets:
  - state=ACCUM, sum=0, count=0;
  - all outputs 0 except sample_ready=1.
- After reset, any pending done from the divider is ignored.
- FSM states: ACCUM, ISSUE, WAIT, OUTPUT. All outputs are registered.
- ACCUM:
  - On sample_valid: sum <= sum + zero-extended sample_data; count <= count+1.
  - Frame closes when frame_end=1, or when a sample makes count reach MAX_COUNT.
  - Simultaneous sample_valid and frame_end: the sample is included, then the frame closes.
  - Close with resulting count>0: go to ISSUE.
  - Close with count=0: go to OUTPUT with mean_out=0 and zero_frame=1; no div_en is issued.
- Sum width: 64 bits cannot overflow for count<2^32; no saturation logic.
- ISSUE (1 cycle): div_en=1; g_dividend_Q=sum, g_divider_Q=count. Go to WAIT.
  - Latency: frame close at edge T gives div_en high in cycle T+1.
- WAIT:
  - div_en=0; operands held; timeout counter starts at 0 on entry.
  - done is accepted from the first WAIT cycle onward; done in any other state is ignored.
  - On done: capture quotient into mean_out, then go to OUTPUT.
  - If the counter reaches TIMEOUT without done: set timeout_err, clear sum and count, go to ACCUM. No mean_valid is produced.
- OUTPUT (1 cycle):
  - mean_valid=1; zero_frame valid this cycle only, otherwise 0.
  - Clear sum, count and the operand outputs; go to ACCUM.
  - Latency: done in cycle D gives mean_valid in cycle D+1.
- sample_ready=0 in ISSUE, WAIT and OUTPUT.
  - sample_valid in those states sets overrun; the sample is discarded.
  - frame_end in those states is ignored.
- overrun and timeout_err clear only on reset.
- mean_out keeps its last value across frames and timeouts.

Test Plan:
1. Samples 10,20,30,40, frame_end with the last one; bench divider model returns done after 70 cycles -> g_dividend_Q=100, g_divider_Q=4, div_en high exactly 1 cycle; mean_out=25 with a 1-cycle mean_valid the cycle after done.
2. 62 samples of 12 plus one of 21, then a separate frame_end cycle -> dividend 765, divisor 63, quotient 12 -> mean_out=12, zero_frame=0.
3. frame_end with no samples since reset -> div_en never asserts; mean_valid=1, zero_frame=1, mean_out=0 one cycle after frame_end.
4. MAX_COUNT=8, 10 consecutive samples of 5 -> auto-close after the 8th (dividend 40, divisor 8); samples 9 and 10 dropped, overrun=1; mean_out=5.
5. TIMEOUT=100, divider never asserts done -> timeout_err=1 on the 100th WAIT cycle; no mean_valid; sample_ready=1 the next cycle; next frame 3,5 -> mean_out=4.
6. Reset asserted during WAIT, then the model asserts done 5 cycles later with quotient 99 -> all outputs zeroed one edge after reset; the late done is ignored; mean_valid stays 0 and mean_out=0.
